// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART state encoding, character-length codes and defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int c_oversample_def = 16;

  localparam logic [1:0] c_db_5 = 2'b00;
  localparam logic [1:0] c_db_6 = 2'b01;
  localparam logic [1:0] c_db_7 = 2'b10;
  localparam logic [1:0] c_db_8 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Index of the final data bit for a character-length code (4..7).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] db);
    return {1'b0, db} + 3'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// uart_baud_gen : oversample tick generator, one tick every baud_div+1 clocks
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clear,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  // >= keeps the counter from running past a divisor that shrank mid-count.
  assign tick = (r_cnt >= baud_div);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : oversampling UART receiver with parity/framing checks, overrun
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = c_oversample_def,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic             rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int             c_tw      = $clog2(OVERSAMPLE);
  localparam logic [c_tw-1:0] c_half_m1 = c_tw'(OVERSAMPLE / 2 - 1);
  localparam logic [c_tw-1:0] c_full_m1 = c_tw'(OVERSAMPLE - 1);

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_sync2;
  logic             w_rx, w_tick, w_start, w_sample, w_done;
  logic [c_tw-1:0]  r_tcnt;
  logic [2:0]       r_bcnt;
  logic [7:0]       r_shift;
  logic             r_perr, r_ferr, r_done;
  logic [1:0]       r_cfg_bits;
  logic             r_cfg_par, r_cfg_odd, r_cfg_stop2;
  logic [DIV_W-1:0] r_div;

  assign w_rx = r_sync2;
  assign busy = (r_state != ST_IDLE);

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .arst     (arst),
    .clear    (w_start),
    .baud_div (r_div),
    .tick     (w_tick)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_sample    = 1'b0;
    if (r_state == ST_START) begin
      w_sample = w_tick && (r_tcnt == c_half_m1);
    end else if (r_state != ST_IDLE) begin
      w_sample = w_tick && (r_tcnt == c_full_m1);
    end
    case (r_state)
      ST_IDLE: begin
        if (!w_rx) begin
          w_state_nxt = ST_START;
          w_start     = 1'b1;
        end
      end
      ST_START:  if (w_sample) w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (w_sample && (r_bcnt == last_bit_idx(r_cfg_bits))) begin
          w_state_nxt = r_cfg_par ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (w_sample) w_state_nxt = ST_STOP;
      ST_STOP: begin
        if (w_sample && (r_bcnt[0] || !r_cfg_stop2)) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_start     = 1'b0;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_tcnt      <= '0;
      r_bcnt      <= '0;
      r_shift     <= '0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_bits  <= '0;
      r_cfg_par   <= 1'b0;
      r_cfg_odd   <= 1'b0;
      r_cfg_stop2 <= 1'b0;
      r_div       <= '0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_done  <= w_done;
      if (w_start) begin
        r_tcnt      <= '0;
        r_bcnt      <= '0;
        r_shift     <= '0;
        r_perr      <= 1'b0;
        r_ferr      <= 1'b0;
        r_cfg_bits  <= data_bits;
        r_cfg_par   <= parity_en;
        r_cfg_odd   <= parity_odd;
        r_cfg_stop2 <= stop2;
        r_div       <= baud_div;
      end else begin
        if (w_tick && (r_state != ST_IDLE)) begin
          r_tcnt <= (r_state == ST_START && r_tcnt == c_half_m1) ? '0 : r_tcnt + 1'b1;
        end
        // Bit counter restarts whenever a sample moves the FSM to a new state.
        if (w_sample) begin
          r_bcnt <= (w_state_nxt != r_state) ? 3'd0 : r_bcnt + 3'd1;
        end
        if (w_sample && r_state == ST_DATA) begin
          r_shift[r_bcnt] <= w_rx;
        end
        if (w_sample && r_state == ST_PARITY) begin
          r_perr <= ((^r_shift) ^ r_cfg_odd) != w_rx;
        end
        if (w_sample && r_state == ST_STOP && !w_rx) begin
          r_ferr <= 1'b1;
        end
      end
    end
  end

  // Output holding register; a completing character takes priority over the clear.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (r_done && (!rx_valid || rx_ready)) begin
        rx_data    <= r_shift;
        parity_err <= r_perr;
        frame_err  <= r_ferr;
        rx_valid   <= 1'b1;
      end else if (r_done) begin
        overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : directed frames into uart_rx, scoreboarded against expectations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int c_bit_clks = 32;

  logic        clk = 1'b0;
  logic        arst, en, parity_en, parity_odd, stop2, rx, rx_ready;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_err, frame_err, overrun, busy;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_ovr    = 0;
  logic [9:0]  exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(.OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk        (clk),
    .arst       (arst),
    .en         (en),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                            input logic par_bit, input logic has_s2, input logic s2);
    drive(1'b0, c_bit_clks);
    for (int i = 0; i < nbits; i++) drive(d[i], c_bit_clks);
    if (has_par) drive(par_bit, c_bit_clks);
    drive(1'b1, c_bit_clks);
    // A low second stop bit is cut short so the line is high again well before
    // the receiver's restart sample; otherwise it would look like a new start bit.
    if (has_s2) begin
      drive(s2, s2 ? c_bit_clks : 24);
    end
    drive(1'b1, 64);
  endtask

  // Monitor: each new presentation of rx_valid pops and compares one expectation.
  initial begin : monitor
    logic       prev;
    logic [9:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (arst) begin
        prev = 1'b0;
      end else begin
        if (overrun) n_ovr++;
        if (rx_valid && !prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_char", {22'd0, rx_data, parity_err, frame_err}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("char", {22'd0, rx_data, parity_err, frame_err}, {22'd0, e});
          end
        end
        prev = rx_valid;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    arst = 1'b1; en = 1'b1; rx = 1'b1; rx_ready = 1'b1;
    baud_div = 16'd1; data_bits = 2'b11; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",   {24'd0, rx_data}, 32'h00);
    check("rst_valid",  {31'd0, rx_valid}, 32'd0);
    check("rst_perr",   {31'd0, parity_err}, 32'd0);
    check("rst_ferr",   {31'd0, frame_err}, 32'd0);
    check("rst_ovr",    {31'd0, overrun}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    arst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 8N1 0xA5
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0);

    // 7E1 0x35: four ones, so the even parity bit is 0
    data_bits = 2'b10; parity_en = 1'b1; parity_odd = 1'b0;
    exp_q.push_back({8'h35, 1'b0, 1'b0});
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({8'h35, 1'b1, 1'b0});
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b0);

    // 8N2 0x5A, second stop bit low
    data_bits = 2'b11; parity_en = 1'b0; stop2 = 1'b1;
    exp_q.push_back({8'h5A, 1'b0, 1'b1});
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    stop2 = 1'b0;

    // False start: 4 ticks low
    drive(1'b0, 8);
    check("false_start_busy", {31'd0, busy}, 32'd1);
    drive(1'b1, 40);
    check("false_start_idle", {31'd0, busy}, 32'd0);

    // Overrun: 0x11 held, 0x22 dropped
    rx_ready = 1'b0;
    exp_q.push_back({8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_held_data",  {24'd0, rx_data}, 32'h11);
    check("ovr_held_valid", {31'd0, rx_valid}, 32'd1);
    check("ovr_pulses",     n_ovr, 32'd1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ready_clears_valid", {31'd0, rx_valid}, 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // Reset during data bit 3 of 0x77
    drive(1'b0, c_bit_clks);
    for (int i = 0; i < 3; i++) drive(1'b1, c_bit_clks);
    drive(1'b0, 16);
    arst = 1'b1;
    rx   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_busy",  {31'd0, busy}, 32'd0);
    check("mid_rst_data",  {24'd0, rx_data}, 32'h00);
    check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("mid_rst_errs",  {30'd0, parity_err, frame_err}, 32'd0);
    arst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    exp_q.push_back({8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (20) @(posedge clk);
    #1;
    check("all_chars_seen", exp_q.size(), 32'd0);
    check("ovr_total",      n_ovr, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
